// File: rtl/mux_operand_sequencer.sv
// Operand sequencer: buffers four upstream words, then steps a 4-to-1 mux select through a
// programmable order, one step per downstream handshake.
module mux_operand_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [7:0]       sel_order,
   output logic [WIDTH-1:0] op0,
   output logic [WIDTH-1:0] op1,
   output logic [WIDTH-1:0] op2,
   output logic [WIDTH-1:0] op3,
   output logic             sel1,
   output logic             sel0,
   output logic             sel_valid,
   input  logic             sel_ready,
   output logic             frame_done
);

   typedef enum logic {StFill, StDrain} state_t;

   state_t           state_q, state_d;
   logic [1:0]       fill_q, fill_d;
   logic [1:0]       step_q, step_d;
   logic [7:0]       order_q, order_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] ent_q [4];
   logic             wr_en;
   logic [1:0]       sel_cur;

   // Flush discards any handshake presented in the same cycle.
   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      step_d  = step_q;
      order_d = order_q;
      done_d  = 1'b0;
      wr_en   = 1'b0;
      if (flush) begin
         state_d = StFill;
         fill_d  = 2'd0;
         step_d  = 2'd0;
      end else begin
         unique case (state_q)
            StFill: begin
               if (in_valid) begin
                  wr_en  = 1'b1;
                  fill_d = fill_q + 2'd1;
                  if (fill_q == 2'd3) begin
                     order_d = sel_order;
                     state_d = StDrain;
                     step_d  = 2'd0;
                     fill_d  = 2'd0;
                  end
               end
            end
            StDrain: begin
               if (sel_ready) begin
                  if (step_q == 2'd3) begin
                     done_d  = 1'b1;
                     state_d = StFill;
                     step_d  = 2'd0;
                     fill_d  = 2'd0;
                  end else begin
                     step_d = step_q + 2'd1;
                  end
               end
            end
            default: state_d = StFill;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFill;
         fill_q  <= 2'd0;
         step_q  <= 2'd0;
         order_q <= 8'd0;
         done_q  <= 1'b0;
         for (int i = 0; i < 4; i++) ent_q[i] <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         step_q  <= step_d;
         order_q <= order_d;
         done_q  <= done_d;
         if (wr_en) ent_q[fill_q] <= in_data;
      end
   end

   assign sel_cur = order_q[{step_q, 1'b0} +: 2];

   always_comb begin
      in_ready   = (state_q == StFill);
      sel_valid  = (state_q == StDrain);
      sel1       = sel_valid & sel_cur[1];
      sel0       = sel_valid & sel_cur[0];
      frame_done = done_q;
      op0        = ent_q[0];
      op1        = ent_q[1];
      op2        = ent_q[2];
      op3        = ent_q[3];
   end

endmodule

// File: tb/tb_mux_operand_sequencer.sv
// Scoreboard bench for mux_operand_sequencer: directed frames push expected selects/operands,
// a negedge monitor pops and compares on every downstream handshake.
module tb_mux_operand_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, flush, in_valid, in_ready, sel_ready;
   logic [7:0] in_data, sel_order;
   logic [7:0] op0, op1, op2, op3;
   logic       sel1, sel0, sel_valid, frame_done;

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] ops;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;
   int   done_seen = 0;
   logic prev_done = 1'b0;

   mux_operand_sequencer #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .sel_order  (sel_order),
      .op0        (op0),
      .op1        (op1),
      .op2        (op2),
      .op3        (op3),
      .sel1       (sel1),
      .sel0       (sel0),
      .sel_valid  (sel_valid),
      .sel_ready  (sel_ready),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_frame(input logic [7:0] ord, input logic [31:0] ops, input int nsteps);
      for (int k = 0; k < nsteps; k++) begin
         exp_t e;
         e.sel = 2'((ord >> (2 * k)) & 8'h3);
         e.ops = ops;
         sb_q.push_back(e);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic [7:0] ord);
      int n = 0;
      in_valid  = 1'b1;
      in_data   = d;
      sel_order = ord;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      @(negedge clk);
      while (!frame_done && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!frame_done) check("done_timeout", {31'd0, frame_done}, 32'd1);
   endtask

   // Monitor: every accepted select must match the next scoreboard entry.
   always @(negedge clk) begin
      if (rst_n && sel_valid && sel_ready && !flush) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_hs", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_sel", {30'd0, sel1, sel0}, {30'd0, e.sel});
            check("sb_ops", {op3, op2, op1, op0}, e.ops);
         end
      end
      if (frame_done) begin
         done_seen++;
         check("done_one_cycle", {31'd0, prev_done}, 32'd0);
      end
      prev_done = frame_done;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] w [8];
      int idx, cyc;
      logic acc;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      sel_order = 8'h00; sel_ready = 1'b0;
      #1;
      check("rst_ops", {op3, op2, op1, op0}, 32'd0);
      check("rst_ready", {31'd0, in_ready}, 32'd1);
      check("rst_selv", {29'd0, sel_valid, sel1, sel0}, 32'd0);
      check("rst_done", {31'd0, frame_done}, 32'd0);
      #11 rst_n = 1'b1;
      @(posedge clk); #1;

      // Frame 1: in-order selects, sel_ready held high.
      push_frame(8'hE4, 32'h44332211, 4);
      sel_ready = 1'b1;
      send(8'h11, 8'hE4); send(8'h22, 8'hE4); send(8'h33, 8'hE4); send(8'h44, 8'hE4);
      @(negedge clk);
      check("t1_first_sel", {30'd0, sel_valid, sel1 | sel0}, 32'd2);
      check("t1_ready_low", {31'd0, in_ready}, 32'd0);
      repeat (3) @(negedge clk);
      @(negedge clk);
      check("t1_done", {31'd0, frame_done}, 32'd1);
      check("t1_ready_back", {31'd0, in_ready}, 32'd1);
      check("t1_selv_low", {31'd0, sel_valid}, 32'd0);
      @(posedge clk); #1;

      // Frame 2: reversed order with sel_ready toggling.
      sel_ready = 1'b0;
      push_frame(8'h1B, 32'h84838281, 4);
      send(8'h81, 8'h1B); send(8'h82, 8'h1B); send(8'h83, 8'h1B); send(8'h84, 8'h1B);
      for (int k = 0; k < 4; k++) begin
         sel_ready = 1'b1;
         @(posedge clk); #1;
         sel_ready = 1'b0;
         @(negedge clk);
         if (k < 3) begin
            check("t2_hold_sel", {29'd0, sel_valid, sel1, sel0}, 32'd4 | (32'd2 - k));
         end else begin
            check("t2_done", {31'd0, frame_done}, 32'd1);
            check("t2_selv_low", {31'd0, sel_valid}, 32'd0);
         end
         @(posedge clk); #1;
      end

      // Frame 3: input offered during DRAIN must be ignored.
      push_frame(8'hE4, 32'hA4A3A2A1, 4);
      send(8'hA1, 8'hE4); send(8'hA2, 8'hE4); send(8'hA3, 8'hE4); send(8'hA4, 8'hE4);
      in_valid = 1'b1; in_data = 8'hFF;
      repeat (3) begin
         @(negedge clk);
         check("t3_ready_low", {31'd0, in_ready}, 32'd0);
         check("t3_ops_hold", {op3, op2, op1, op0}, 32'hA4A3A2A1);
      end
      @(posedge clk); #1;
      in_data = 8'h55; sel_ready = 1'b1;
      wait_done();
      check("t3_ready_at_done", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; sel_ready = 1'b0;
      @(negedge clk);
      check("t3_next_op0", {24'd0, op0}, 32'h55);
      check("t3_op1_kept", {24'd0, op1}, 32'hA2);
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;

      // Frame 4: flush at step 2 alongside a select handshake.
      push_frame(8'hE4, 32'hB4B3B2B1, 2);
      send(8'hB1, 8'hE4); send(8'hB2, 8'hE4); send(8'hB3, 8'hE4); send(8'hB4, 8'hE4);
      sel_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; sel_ready = 1'b0;
      @(negedge clk);
      check("t4_no_done", {31'd0, frame_done}, 32'd0);
      check("t4_fill_state", {29'd0, in_ready, sel_valid, sel1 | sel0}, 32'd4);
      check("t4_ops_kept", {op3, op2, op1, op0}, 32'hB4B3B2B1);
      @(posedge clk); #1;
      send(8'hC1, 8'h1B);
      @(negedge clk);
      check("t4_fill_restart", {op1, op0}, 32'hB2C1);
      @(posedge clk); #1;

      // Frame 5: async reset mid-DRAIN, then an all-zero order.
      send(8'hC2, 8'h1B); send(8'hC3, 8'h1B); send(8'hC4, 8'h1B);
      @(negedge clk);
      check("t5_drain_sel", {29'd0, sel_valid, sel1, sel0}, 32'd7);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_ops", {op3, op2, op1, op0}, 32'd0);
      check("t5_rst_ctrl", {28'd0, in_ready, sel_valid, sel1, sel0}, 32'd8);
      check("t5_rst_done", {31'd0, frame_done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      push_frame(8'h00, 32'hD4D3D2D1, 4);
      sel_ready = 1'b1;
      send(8'hD1, 8'h00); send(8'hD2, 8'h00); send(8'hD3, 8'h00); send(8'hD4, 8'h00);
      wait_done();
      @(posedge clk); #1;

      // Frames 6/7: back-to-back with in_valid held high.
      w = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
      push_frame(8'h4E, 32'h64636261, 4);
      push_frame(8'hB1, 32'h68676665, 4);
      idx = 0; cyc = 0;
      in_valid = 1'b1; in_data = w[0]; sel_order = 8'h4E;
      while (idx < 8 && cyc < 100) begin
         @(negedge clk);
         acc = in_ready;
         if (frame_done) check("t6_ready_at_done", {31'd0, in_ready}, 32'd1);
         @(posedge clk); #1;
         if (acc) idx++;
         if (idx < 8) begin
            in_data   = w[idx];
            sel_order = (idx < 4) ? 8'h4E : 8'hB1;
         end
         cyc++;
      end
      in_valid = 1'b0;
      check("t6_stream_cycles", cyc, 32'd12);
      wait_done();
      @(posedge clk); #1;

      check("sb_empty", sb_q.size(), 32'd0);
      check("done_count", done_seen, 32'd6);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
